// File: rtl/systolic_skew_feeder.sv
// Diagonal skew feeder for one edge of the systolic MAC array: lane i is delayed 1+i cycles.
// Optional macro SYSTOLIC_SKEW_ABORT_EN adds an abort input that drops a stream in flight.
module systolic_skew_feeder #(
  parameter int BW   = 32,
  parameter int N    = 4,
  parameter int KMAX = 16
) (
  input  logic                       clk,
  input  logic                       rst,
`ifdef SYSTOLIC_SKEW_ABORT_EN
  input  logic                       abort,
`endif
  input  logic                       start,
  input  logic [$clog2(KMAX+1)-1:0]  k_len,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N*BW-1:0]            in_data,
  output logic [N*BW-1:0]            out_data,
  output logic [N-1:0]               lane_valid,
  output logic                       busy,
  output logic                       done
);

  localparam int KW = $clog2(KMAX+1);
  localparam int FW = (N > 2) ? $clog2(N) : 1;
  localparam logic [KW-1:0] KMAX_W = KW'(KMAX);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(N-2);

  typedef enum logic [1:0] {ST_IDLE, ST_STREAM, ST_FLUSH} state_t;

  state_t          r_state;
  logic [KW-1:0]   r_klen;
  logic [KW-1:0]   r_beat;
  logic [FW-1:0]   r_flush;
  logic            r_done;

  logic            w_hs;
  logic            w_abort;
  logic [KW-1:0]   w_klen;

`ifdef SYSTOLIC_SKEW_ABORT_EN
  assign w_abort = abort && (r_state != ST_IDLE);
`else
  assign w_abort = 1'b0;
`endif

  assign w_klen   = (k_len > KMAX_W) ? KMAX_W : k_len;
  assign in_ready = (r_state == ST_STREAM);
  assign busy     = (r_state != ST_IDLE);
  assign done     = r_done;
  assign w_hs     = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_klen  <= '0;
      r_beat  <= '0;
      r_flush <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_abort) begin
        r_state <= ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (start) begin
              // A zero-length stream completes immediately without ever raising busy.
              if (w_klen == '0) begin
                r_done <= 1'b1;
              end else begin
                r_klen  <= w_klen;
                r_beat  <= '0;
                r_state <= ST_STREAM;
              end
            end
          end
          ST_STREAM: begin
            if (w_hs) begin
              r_beat <= r_beat + KW'(1);
              if (r_beat == r_klen - KW'(1)) begin
                r_state <= ST_FLUSH;
                r_flush <= '0;
              end
            end
          end
          ST_FLUSH: begin
            if (r_flush == FLUSH_LAST) begin
              r_state <= ST_IDLE;
              r_done  <= 1'b1;
            end else begin
              r_flush <= r_flush + FW'(1);
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  // Free-running skew chains: stage 0 captures the beat (or a zero bubble), the last stage drives the edge.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_lane
      logic [BW-1:0] r_pipe [0:gi];
      logic [gi:0]   r_pv;

      always_ff @(posedge clk) begin
        if (!rst || w_abort) begin
          for (int j = 0; j <= gi; j++) r_pipe[j] <= '0;
          r_pv <= '0;
        end else begin
          r_pipe[0] <= w_hs ? in_data[gi*BW +: BW] : '0;
          r_pv[0]   <= w_hs;
          for (int j = 1; j <= gi; j++) begin
            r_pipe[j] <= r_pipe[j-1];
            r_pv[j]   <= r_pv[j-1];
          end
        end
      end

      assign out_data[gi*BW +: BW] = r_pipe[gi];
      assign lane_valid[gi]        = r_pv[gi];
    end
  endgenerate

endmodule
